// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the unified instruction/data memory port arbiter.
package cpu_mem_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MEM_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM stages, the arbiter and the single-port memory.
interface mem_port_arbiter_if
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              i_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // The arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // The pipeline stages and memory as seen from outside the arbiter.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick between the fetch and data requesters.
module rr_arb2
  import cpu_mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_if,
  input  logic   req_mem,
  input  logic   take,
  output logic   valid,
  output owner_t owner
);

  owner_t last_grant;

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    valid = req_if | req_mem;
    owner = OWN_IF;
    if (req_if && req_mem) begin
      owner = (last_grant == OWN_IF) ? OWN_MEM : OWN_IF;
    end else if (req_mem) begin
      owner = OWN_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWN_IF;
    end else if (take) begin
      last_grant <= owner;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences IF fetches and MEM loads/stores onto one fixed-latency memory port.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  arb_state_t       state;
  owner_t           owner;
  logic [CNT_W-1:0] cnt;

  logic   grant_valid;
  owner_t grant_owner;
  logic   grant_take;

  // RESP is excluded so a requester still holding req during its ack is not re-granted.
  assign grant_take = (state == IDLE) && grant_valid;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req_if  (bus.i_req),
    .req_mem (bus.d_req),
    .take    (grant_take),
    .valid   (grant_valid),
    .owner   (grant_owner)
  );

  assign bus.i_stall = bus.i_req & ~bus.i_ack;
  assign bus.d_stall = bus.d_req & ~bus.d_ack;
  assign bus.busy    = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      cnt           <= '0;
      bus.i_ack     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.i_ack  <= 1'b0;
      bus.d_ack  <= 1'b0;
      bus.mem_en <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner      <= grant_owner;
            bus.mem_en <= 1'b1;
            state      <= ISSUE;
            if (grant_owner == OWN_IF) begin
              bus.mem_addr  <= bus.i_addr;
              bus.mem_we    <= 1'b0;
              bus.mem_wdata <= '0;
            end else begin
              bus.mem_addr  <= bus.d_addr;
              bus.mem_we    <= bus.d_we;
              bus.mem_wdata <= bus.d_wdata;
            end
          end
        end
        ISSUE: begin
          cnt   <= CNT_W'(MEM_LATENCY);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          // mem_rdata is valid in the cycle where cnt reads 1; acks are raised on entry to RESP.
          if (cnt == CNT_W'(1)) begin
            state <= RESP;
            if (owner == OWN_IF) begin
              bus.i_rdata <= bus.mem_rdata;
              bus.i_ack   <= 1'b1;
            end else begin
              bus.d_rdata <= bus.mem_we ? '0 : bus.mem_rdata;
              bus.d_ack   <= 1'b1;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus4 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) u_lat1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(4)) u_lat4 (
    .clk (clk), .rst (rst), .bus (bus4)
  );

  function automatic logic [31:0] fill(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory models: read data is presented only in the one cycle it is valid.
  logic [31:0] mem_store [logic [31:0]];
  int          due_cyc  = -1, due1_cyc = -1, due4_cyc = -1;
  logic [31:0] due_data = '0, due1_data = '0, due4_data = '0;

  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we) begin
        mem_store[bus.mem_addr] = bus.mem_wdata;
      end else begin
        due_cyc  <= cyc + L;
        due_data <= mem_store.exists(bus.mem_addr) ? mem_store[bus.mem_addr] : fill(bus.mem_addr);
      end
    end
    if (bus1.mem_en === 1'b1) begin
      due1_cyc  <= cyc + 1;
      due1_data <= fill(bus1.mem_addr);
    end
    if (bus4.mem_en === 1'b1) begin
      due4_cyc  <= cyc + 4;
      due4_data <= fill(bus4.mem_addr);
    end
  end

  assign bus.mem_rdata  = (cyc == due_cyc)  ? due_data  : 32'hBAD0_BAD0;
  assign bus1.mem_rdata = (cyc == due1_cyc) ? due1_data : 32'hBAD0_BAD0;
  assign bus4.mem_rdata = (cyc == due4_cyc) ? due4_data : 32'hBAD0_BAD0;

  typedef struct {
    int          c;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } en_rec_t;
  en_rec_t en_log[$];

  always @(negedge clk) begin
    en_rec_t r;
    if (bus.mem_en === 1'b1) begin
      r.c = cyc; r.addr = bus.mem_addr; r.we = bus.mem_we; r.wdata = bus.mem_wdata;
      en_log.push_back(r);
    end
  end

  // Reference model: architectural memory contents and round-robin history.
  logic [31:0] ref_mem [logic [31:0]];
  owner_t      tb_last;
  logic [31:0] last_i_rdata, last_d_rdata;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_pair(input string tag, input bit use_i, input logic [31:0] ia,
                          input bit use_d, input bit dwe, input logic [31:0] da,
                          input logic [31:0] dwd);
    int          t0, n, ack_c;
    owner_t      first, o;
    int          exp_i_cyc, exp_d_cyc;
    logic [31:0] exp_i_data, exp_d_data;
    bit          i_got, d_got;
    int          e_cyc [2];
    logic [31:0] e_addr [2];
    logic        e_we [2];
    logic [31:0] e_wd [2];

    if (use_i && use_d) first = (tb_last == OWN_IF) ? OWN_MEM : OWN_IF;
    else                first = use_d ? OWN_MEM : OWN_IF;
    n = int'(use_i) + int'(use_d);
    t0 = cyc;
    exp_i_cyc = -1; exp_d_cyc = -1; exp_i_data = '0; exp_d_data = '0;
    for (int k = 0; k < n; k++) begin
      o = (k == 0) ? first : ((first == OWN_IF) ? OWN_MEM : OWN_IF);
      ack_c    = t0 + 2 + L + k * (L + 3);
      e_cyc[k] = t0 + 1 + k * (L + 3);
      if (o == OWN_IF) begin
        exp_i_cyc = ack_c; exp_i_data = ref_read(ia);
        e_addr[k] = ia; e_we[k] = 1'b0; e_wd[k] = '0;
      end else begin
        exp_d_cyc = ack_c;
        e_addr[k] = da; e_we[k] = dwe; e_wd[k] = dwd;
        if (dwe) begin
          ref_mem[da] = dwd; exp_d_data = '0;
        end else begin
          exp_d_data = ref_read(da);
        end
      end
      tb_last = o;
    end

    en_log.delete();
    bus.i_req = use_i; bus.i_addr = ia;
    bus.d_req = use_d; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
    i_got = 1'b0; d_got = 1'b0;
    for (int k = 0; k < 40 && !((i_got || !use_i) && (d_got || !use_d)); k++) begin
      @(negedge clk);
      check({tag, "/i_stall"}, 32'(bus.i_stall), 32'(use_i && (cyc < exp_i_cyc)));
      check({tag, "/d_stall"}, 32'(bus.d_stall), 32'(use_d && (cyc < exp_d_cyc)));
      check({tag, "/ack_overlap"}, 32'(bus.i_ack & bus.d_ack), 32'(0));
      if (bus.i_ack === 1'b1) begin
        check({tag, "/i_ack_cycle"}, 32'(cyc), 32'(exp_i_cyc));
        check({tag, "/i_rdata"}, bus.i_rdata, exp_i_data);
        i_got = 1'b1;
      end
      if (bus.d_ack === 1'b1) begin
        check({tag, "/d_ack_cycle"}, 32'(cyc), 32'(exp_d_cyc));
        check({tag, "/d_rdata"}, bus.d_rdata, exp_d_data);
        d_got = 1'b1;
      end
      @(posedge clk); #1;
      if (i_got) bus.i_req = 1'b0;
      if (d_got) bus.d_req = 1'b0;
      if (k == 0 && use_d && first == OWN_MEM) begin
        bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_we = ~bus.d_we;
      end
    end
    check({tag, "/i_ack_seen"}, 32'(i_got), 32'(use_i));
    check({tag, "/d_ack_seen"}, 32'(d_got), 32'(use_d));
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    if (use_i) last_i_rdata = exp_i_data;
    if (use_d) last_d_rdata = exp_d_data;

    check({tag, "/mem_en_count"}, 32'(en_log.size()), 32'(n));
    for (int k = 0; k < n && k < en_log.size(); k++) begin
      check({tag, "/mem_en_cycle"}, 32'(en_log[k].c), 32'(e_cyc[k]));
      check({tag, "/mem_addr"}, en_log[k].addr, e_addr[k]);
      check({tag, "/mem_we"}, 32'(en_log[k].we), 32'(e_we[k]));
      check({tag, "/mem_wdata"}, en_log[k].wdata, e_wd[k]);
    end

    @(negedge clk);
    check({tag, "/idle_busy"}, 32'(bus.busy), 32'(0));
    check({tag, "/i_rdata_hold"}, bus.i_rdata, last_i_rdata);
    check({tag, "/d_rdata_hold"}, bus.d_rdata, last_d_rdata);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t0, acks, k_end;
    owner_t      exp_owner;
    logic [31:0] ia_cur, da_cur, a1, a4;
    bit          got, got1, got4, use_d_side;
    int          mode;

    rst = 1'b1;
    bus.i_req = 0;  bus.i_addr = '0;  bus.d_req = 0;  bus.d_we = 0;  bus.d_addr = '0;  bus.d_wdata = '0;
    bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = '0; bus1.d_wdata = '0;
    bus4.i_req = 0; bus4.i_addr = '0; bus4.d_req = 0; bus4.d_we = 0; bus4.d_addr = '0; bus4.d_wdata = '0;
    mem_store[32'h10] = 32'h2002_0005;
    ref_mem[32'h10]   = 32'h2002_0005;
    tb_last = OWN_IF;
    last_i_rdata = '0; last_d_rdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/i_ack", 32'(bus.i_ack), 32'(0));
    check("reset/d_ack", 32'(bus.d_ack), 32'(0));
    check("reset/i_rdata", bus.i_rdata, 32'h0);
    check("reset/d_rdata", bus.d_rdata, 32'h0);
    check("reset/mem_en", 32'(bus.mem_en), 32'(0));
    check("reset/mem_we", 32'(bus.mem_we), 32'(0));
    check("reset/mem_addr", bus.mem_addr, 32'h0);
    check("reset/mem_wdata", bus.mem_wdata, 32'h0);
    check("reset/busy", 32'(bus.busy), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_pair("fetch", 1'b1, 32'h0000_0010, 1'b0, 1'b0, '0, '0);
    run_pair("store", 1'b0, '0, 1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
    run_pair("load",  1'b0, '0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);

    // Reset while the fetch is in WAIT; the still-held request must be re-granted cleanly.
    en_log.delete();
    t0 = cyc;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0080;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid/ack_in_wait", 32'(bus.i_ack | bus.d_ack), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid/busy", 32'(bus.busy), 32'(0));
    check("rst_mid/mem_en", 32'(bus.mem_en), 32'(0));
    check("rst_mid/i_ack", 32'(bus.i_ack), 32'(0));
    check("rst_mid/i_rdata", bus.i_rdata, 32'h0);
    last_i_rdata = '0; last_d_rdata = '0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.i_ack === 1'b1) begin
        check("rst_mid/regrant_ack_cycle", 32'(cyc), 32'(t0 + 4 + 1 + L));
        check("rst_mid/regrant_rdata", bus.i_rdata, ref_read(32'h80));
        got = 1'b1;
      end
    end
    check("rst_mid/regrant_seen", 32'(got), 32'(1));
    check("rst_mid/mem_en_count", 32'(en_log.size()), 32'(2));
    if (en_log.size() == 2) begin
      check("rst_mid/first_mem_en", 32'(en_log[0].c), 32'(t0 + 1));
      check("rst_mid/regrant_mem_en", 32'(en_log[1].c), 32'(t0 + 4));
    end
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    last_i_rdata = ref_read(32'h80);
    tb_last = OWN_IF;
    @(posedge clk); #1;

    run_pair("conflict", 1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0040, 32'h0);

    // Both requesters held continuously: service must alternate every L+3 cycles.
    exp_owner = (tb_last == OWN_IF) ? OWN_MEM : OWN_IF;
    ia_cur = 32'h0000_0100; da_cur = 32'h0000_0200;
    bus.i_req = 1'b1; bus.i_addr = ia_cur;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = da_cur; bus.d_wdata = '0;
    t0 = cyc; acks = 0;
    for (int k = 0; k < 80 && acks < 6; k++) begin
      @(negedge clk);
      if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
        check("starve/ack_owner", 32'({bus.i_ack, bus.d_ack}),
              32'((exp_owner == OWN_IF) ? 2'b10 : 2'b01));
        check("starve/ack_cycle", 32'(cyc), 32'(t0 + 2 + L + acks * (L + 3)));
        if (bus.i_ack === 1'b1) begin
          check("starve/i_rdata", bus.i_rdata, ref_read(ia_cur));
          last_i_rdata = ref_read(ia_cur);
          tb_last = OWN_IF;
        end else begin
          check("starve/d_rdata", bus.d_rdata, ref_read(da_cur));
          last_d_rdata = ref_read(da_cur);
          tb_last = OWN_MEM;
        end
        acks++;
        exp_owner = (exp_owner == OWN_IF) ? OWN_MEM : OWN_IF;
        @(posedge clk); #1;
        if (acks == 6) begin
          bus.i_req = 1'b0; bus.d_req = 1'b0;
        end else if (tb_last == OWN_IF) begin
          ia_cur = ia_cur + 32'h4; bus.i_addr = ia_cur;
        end else begin
          da_cur = da_cur + 32'h4; bus.d_addr = da_cur;
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    check("starve/ack_total", 32'(acks), 32'(6));
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 24; n++) begin
      mode = int'($urandom_range(0, 2));
      run_pair("rand", mode != 1, 32'($urandom_range(0, 15)) << 2,
               mode != 0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
    end

    // Latency sweep on the L=1 and L=4 instances, fetch path then load path.
    for (int r = 0; r < 2; r++) begin
      use_d_side = (r == 1);
      a1 = 32'($urandom_range(0, 255)) << 2;
      a4 = 32'($urandom_range(0, 255)) << 2;
      t0 = cyc;
      bus1.i_req = !use_d_side; bus1.i_addr = a1; bus1.d_req = use_d_side; bus1.d_addr = a1;
      bus4.i_req = !use_d_side; bus4.i_addr = a4; bus4.d_req = use_d_side; bus4.d_addr = a4;
      got1 = 1'b0; got4 = 1'b0;
      k_end = 0;
      for (int k = 0; k < 30 && !(got1 && got4); k++) begin
        @(negedge clk);
        if ((bus1.i_ack | bus1.d_ack) === 1'b1) begin
          check("lat1/ack_cycle", 32'(cyc), 32'(t0 + 3));
          check("lat1/rdata", use_d_side ? bus1.d_rdata : bus1.i_rdata, fill(a1));
          got1 = 1'b1;
        end
        if ((bus4.i_ack | bus4.d_ack) === 1'b1) begin
          check("lat4/ack_cycle", 32'(cyc), 32'(t0 + 6));
          check("lat4/rdata", use_d_side ? bus4.d_rdata : bus4.i_rdata, fill(a4));
          got4 = 1'b1;
        end
        @(posedge clk); #1;
        if (got1) begin bus1.i_req = 1'b0; bus1.d_req = 1'b0; end
        if (got4) begin bus4.i_req = 1'b0; bus4.d_req = 1'b0; end
        k_end = k;
      end
      check("lat1/ack_seen", 32'(got1), 32'(1));
      check("lat4/ack_seen", 32'(got4), 32'(1));
      bus1.i_req = 1'b0; bus1.d_req = 1'b0; bus4.i_req = 1'b0; bus4.d_req = 1'b0;
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
